// File: rtl/acc_loader.sv
// ---------------------------------------------------------------------------
// acc_loader
//
// Register-mapped byte loader. A 32-bit word written to DATA is unpacked into
// four bytes, lane 0 first. One byte is written per cycle into the selected
// destination RAM bank, at a pointer that post-increments and wraps.
// An optional LIMIT stops the stream and raises a one-cycle done pulse.
//
// Optional feature (compile-time macro):
//   ACC_LOADER_BROADCAST_EN - when defined, CTRL[4]=1 writes every bank at
//                             once. When undefined, CTRL[4] is ignored and
//                             reads back as 0.
//
// Parameters:
//   NUM_BANKS - number of destination banks (1..16)
//   ADDR_W    - bank address width (below 32)
//   DATA_W    - byte lane width (8; four lanes per 32-bit word)
//
// Ports:
//   clk          - clock, everything on the rising edge
//   reset        - synchronous active-high reset
//   chipselect   - slave select
//   write, read  - access strobes
//   address[2:0] - 0 CTRL, 1 DATA, 2 BASE, 3 LIMIT, 4 STATUS
//   writedata    - register write data
//   readdata     - registered read data, valid the cycle after acceptance
//   waitrequest  - stall; an access is not taken while it is high
//   wren         - one-hot bank write enable (all ones in broadcast)
//   waddr        - bank write address
//   wdata        - bank write byte
//   done         - one-cycle pulse with the byte that reaches LIMIT
// ---------------------------------------------------------------------------
module acc_loader #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 write,
    input  logic                 read,
    input  logic [2:0]           address,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 waitrequest,
    output logic [NUM_BANKS-1:0] wren,
    output logic [ADDR_W-1:0]    waddr,
    output logic [DATA_W-1:0]    wdata,
    output logic                 done
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_DATA   = 3'd1;
    localparam logic [2:0] ADDR_BASE   = 3'd2;
    localparam logic [2:0] ADDR_LIMIT  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    localparam logic [4:0] BANK_LIMIT  = 5'(NUM_BANKS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UNPACK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [1:0]            r_lane;
    logic [1:0]            w_laneNext;

    logic [31:0]           r_word;
    logic [ADDR_W-1:0]     r_ptr;
    logic [15:0]           r_count;
    logic [3:0]            r_ctrlBank;
    logic                  r_ctrlBcast;
    logic [ADDR_W-1:0]     r_base;
    logic [15:0]           r_limit;
    logic                  r_err;
    logic                  r_doneSticky;

    logic [31:0]           r_readdata;
    logic [NUM_BANKS-1:0]  r_wren;
    logic [ADDR_W-1:0]     r_waddr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_done;

    logic                  w_stall;
    logic                  w_wrTake;
    logic                  w_rdTake;
    logic                  w_dataWr;
    logic                  w_ctrlWr;
    logic                  w_startWr;
    logic                  w_baseWr;
    logic                  w_limitWr;
    logic                  w_bankBad;
    logic                  w_emit;
    logic [15:0]           w_countInc;
    logic                  w_limitHit;
    logic                  w_dataOk;
    logic                  w_dataRej;
    logic                  w_busy;
    logic [NUM_BANKS-1:0]  w_bankMask;
    logic [31:0]           w_rdMux;

    // The bus is stalled during lanes 0..2 only. In lane 3 the next access is
    // taken, so a DATA write landing there continues the stream without a gap.
    assign w_busy      = (r_state == S_UNPACK);
    assign w_stall     = w_busy && (r_lane != 2'd3);
    assign waitrequest = ~reset & chipselect & (read | write) & w_stall;

    assign w_wrTake  = chipselect & write & ~w_stall;
    assign w_rdTake  = chipselect & read & ~w_stall;
    assign w_dataWr  = w_wrTake && (address == ADDR_DATA);
    assign w_ctrlWr  = w_wrTake && (address == ADDR_CTRL);
    assign w_startWr = w_ctrlWr && writedata[8];
    assign w_baseWr  = w_wrTake && (address == ADDR_BASE);
    assign w_limitWr = w_wrTake && (address == ADDR_LIMIT);

    // A byte leaves the unpacker on every UNPACK cycle. The limit is checked
    // against the count including this byte, so done lines up with it.
    assign w_bankBad  = ({1'b0, r_ctrlBank} >= BANK_LIMIT);
    assign w_emit     = w_busy;
    assign w_countInc = r_count + 16'd1;
    assign w_limitHit = w_emit && (r_limit != 16'd0) && (w_countInc == r_limit);

    // A DATA write that arrives in lane 3 while the limit is hit is taken
    // off the bus but discarded. It is flagged like any other refused word.
    assign w_dataOk  = w_dataWr && !r_doneSticky && !w_bankBad && !w_limitHit;
    assign w_dataRej = w_dataWr && !w_dataOk;

    // Bank enable pattern for the current CTRL setting; broadcast overrides
    // the one-hot select when it is compiled in.
    always_comb begin
        w_bankMask = NUM_BANKS'(1) << r_ctrlBank;
`ifdef ACC_LOADER_BROADCAST_EN
        if (r_ctrlBcast) begin
            w_bankMask = '1;
        end
`endif
    end

    // State register for the unpack FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lane  <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_lane  <= w_laneNext;
        end
    end

    // Next-state logic. Reaching the limit drops whatever lanes remain. Lane 3
    // either chains straight into a newly accepted word or falls back to IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_laneNext  = r_lane;
        case (r_state)
            S_IDLE: begin
                if (w_dataOk) begin
                    w_stateNext = S_UNPACK;
                    w_laneNext  = 2'd0;
                end
            end
            S_UNPACK: begin
                if (w_limitHit) begin
                    w_stateNext = S_IDLE;
                    w_laneNext  = 2'd0;
                end else if (r_lane == 2'd3) begin
                    w_stateNext = w_dataOk ? S_UNPACK : S_IDLE;
                    w_laneNext  = 2'd0;
                end else begin
                    w_laneNext  = r_lane + 2'd1;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_laneNext  = 2'd0;
            end
        endcase
    end

    // Register file and write pointer. A start command takes priority over an
    // in-flight byte, so the pointer and count always restart cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word       <= '0;
            r_ptr        <= '0;
            r_count      <= '0;
            r_ctrlBank   <= '0;
            r_ctrlBcast  <= 1'b0;
            r_base       <= '0;
            r_limit      <= '0;
            r_err        <= 1'b0;
            r_doneSticky <= 1'b0;
        end else begin
            if (w_dataOk) begin
                r_word <= writedata;
            end

            if (w_ctrlWr) begin
                r_ctrlBank <= writedata[3:0];
`ifdef ACC_LOADER_BROADCAST_EN
                r_ctrlBcast <= writedata[4];
`else
                r_ctrlBcast <= 1'b0;
`endif
            end

            if (w_baseWr) begin
                r_base <= writedata[ADDR_W-1:0];
            end

            if (w_limitWr) begin
                r_limit <= writedata[15:0];
            end

            if (w_startWr) begin
                r_ptr <= r_base;
            end else if (w_baseWr && (r_state == S_IDLE)) begin
                r_ptr <= writedata[ADDR_W-1:0];
            end else if (w_emit) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end

            if (w_startWr) begin
                r_count <= '0;
            end else if (w_emit) begin
                r_count <= w_countInc;
            end

            if (w_startWr) begin
                r_doneSticky <= 1'b0;
            end else if (w_limitHit) begin
                r_doneSticky <= 1'b1;
            end

            if (w_startWr) begin
                r_err <= 1'b0;
            end else if (w_dataRej) begin
                r_err <= 1'b1;
            end
        end
    end

    // Bank write port. It is registered, so each byte appears the cycle after
    // its lane is selected, and the first byte one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wren  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_limitHit;
            if (w_emit) begin
                r_wren  <= w_bankMask;
                r_waddr <= r_ptr;
                r_wdata <= r_word[{r_lane, 3'b000} +: DATA_W];
            end else begin
                r_wren  <= '0;
            end
        end
    end

    // Read mux. Reading never changes any state.
    always_comb begin
        w_rdMux = '0;
        case (address)
            ADDR_CTRL:   w_rdMux = {27'd0, r_ctrlBcast, r_ctrlBank};
            ADDR_DATA:   w_rdMux = r_word;
            ADDR_BASE:   w_rdMux[ADDR_W-1:0] = r_base;
            ADDR_LIMIT:  w_rdMux = {16'd0, r_limit};
            ADDR_STATUS: w_rdMux = {r_count, 13'd0, r_err, r_doneSticky, w_busy};
            default:     w_rdMux = '0;
        endcase
    end

    // Read data is captured on acceptance and held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rdTake) begin
            r_readdata <= w_rdMux;
        end
    end

    assign readdata = r_readdata;
    assign wren     = r_wren;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign done     = r_done;

endmodule

// File: tb/tb_acc_loader.sv
// ---------------------------------------------------------------------------
// tb_acc_loader
//
// Self-checking bench for acc_loader with default parameters (4 banks,
// 10-bit addresses). Each accepted DATA word pushes its expected bytes into a
// scoreboard queue: bank enable, address, byte, done flag and cycle number.
// A monitor on the falling edge pops and compares every bank write.
// A vector table covers single-word loads. Hand-written sequences cover
// back-to-back words, LIMIT/done/err, a bad bank index, and mid-word reset.
// Define ACC_LOADER_BROADCAST_EN to match a DUT built with broadcast enabled.
// ---------------------------------------------------------------------------
module tb_acc_loader;

    localparam int NB = 4;
    localparam int AW = 10;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DATA   = 3'd1;
    localparam logic [2:0] A_BASE   = 3'd2;
    localparam logic [2:0] A_LIMIT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    logic          clk;
    logic          reset;
    logic          chipselect;
    logic          write;
    logic          read;
    logic [2:0]    address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [NB-1:0] wren;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          done;

    typedef struct {
        logic [NB-1:0] wren;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [31:0]   ctrl;
        logic [31:0]   base;
        logic [31:0]   data;
        logic [NB-1:0] expWren;
        logic [31:0]   expCtrl;
    } vec_t;

    exp_t sbQ[$];
    exp_t monEntry;
    vec_t vec[5];

    int   nChecks = 0;
    int   nFail   = 0;
    int   cyc     = 0;
    logic monEn   = 1'b0;

    acc_loader #(
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .wren        (wren),
        .waddr       (waddr),
        .wdata       (wdata),
        .done        (done)
    );

    // Free-running clock and an edge counter used to time the bank writes.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFail++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Every bank write must match the head of the scoreboard. Any write or
    // done pulse with nothing expected is an error.
    always @(negedge clk) begin
        if (monEn) begin
            if (wren !== '0) begin
                if (sbQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("[TB] FAIL unexpectedWrite: got wren=%b addr=0x%03h data=0x%02h, expected no write",
                             wren, waddr, wdata);
                end else begin
                    monEntry = sbQ.pop_front();
                    checkOutput("wren",  32'(wren),  32'(monEntry.wren));
                    checkOutput("waddr", 32'(waddr), 32'(monEntry.addr));
                    checkOutput("wdata", 32'(wdata), 32'(monEntry.data));
                    checkOutput("done",  32'(done),  32'(monEntry.done));
                    checkOutput("byteCycle", 32'(cyc), 32'(monEntry.cyc));
                end
            end else if (done !== 1'b0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL strayDone: got done=%b, expected 0 with no write", done);
            end
        end
    end

    // Bus write. It is entered and left 1 time unit after a rising edge. It
    // returns the stall count and the index of the edge that took the access.
    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d,
                                 output int stalls, output int acc);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        stalls     = 0;
        while (waitrequest === 1'b1 && stalls < 40) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 40) timeoutFail("writeStall");
        @(posedge clk);
        #1;
        acc        = cyc;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int s;
        int c;
        applyStimulus(a, d, s, c);
    endtask

    task automatic readReg(input logic [2:0] a, output logic [31:0] d);
        int stalls;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        stalls     = 0;
        while (waitrequest === 1'b1 && stalls < 40) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 40) timeoutFail("readStall");
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [2:0] a, input logic [31:0] expected);
        logic [31:0] d;
        readReg(a, d);
        checkOutput(name, d, expected);
    endtask

    // Expected bytes of a word accepted at edge acc. Byte i lands at edge
    // acc+1+i, lane i of the word, at consecutive (wrapping) addresses.
    task automatic pushWord(input int acc, input logic [31:0] data, input logic [NB-1:0] bankEn,
                            input logic [AW-1:0] addr0, input int nBytes, input int doneAt);
        exp_t e;
        for (int i = 0; i < nBytes; i++) begin
            e.wren = bankEn;
            e.addr = addr0 + AW'(i);
            e.data = data[8*i +: 8];
            e.done = (i == doneAt);
            e.cyc  = acc + 1 + i;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st1;
        int st2;
        int acc1;
        int acc2;

        vec[0] = '{ctrl: 32'h01, base: 32'h010, data: 32'hDDCCBBAA, expWren: 4'b0010, expCtrl: 32'h01};
        vec[1] = '{ctrl: 32'h00, base: 32'h020, data: 32'h44332211, expWren: 4'b0001, expCtrl: 32'h00};
        vec[2] = '{ctrl: 32'h03, base: 32'h3FE, data: 32'h0D0C0B0A, expWren: 4'b1000, expCtrl: 32'h03};
        vec[3] = '{ctrl: 32'h02, base: 32'h155, data: 32'hA5A55A5A, expWren: 4'b0100, expCtrl: 32'h02};
`ifdef ACC_LOADER_BROADCAST_EN
        vec[4] = '{ctrl: 32'h10, base: 32'h200, data: 32'h96877869, expWren: 4'b1111, expCtrl: 32'h10};
`else
        vec[4] = '{ctrl: 32'h10, base: 32'h200, data: 32'h96877869, expWren: 4'b0001, expCtrl: 32'h00};
`endif

        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 3'd0;
        writedata  = 32'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetWren",        32'(wren),        32'd0);
        checkOutput("resetWaddr",       32'(waddr),       32'd0);
        checkOutput("resetWdata",       32'(wdata),       32'd0);
        checkOutput("resetDone",        32'(done),        32'd0);
        checkOutput("resetReaddata",    readdata,         32'd0);
        checkOutput("resetWaitrequest", 32'(waitrequest), 32'd0);
        reset = 1'b0;
        monEn = 1'b1;
        @(posedge clk);
        #1;
        checkReg("resetStatus", A_STATUS, 32'd0);

        // Single-word loads from the vector table.
        for (int i = 0; i < 5; i++) begin
            wr(A_BASE, vec[i].base);
            wr(A_CTRL, 32'h100 | vec[i].ctrl);
            applyStimulus(A_DATA, vec[i].data, st1, acc1);
            pushWord(acc1, vec[i].data, vec[i].expWren, vec[i].base[AW-1:0], 4, -1);
            checkOutput("vecStalls", 32'(st1), 32'd0);
            waitDrain();
            checkReg("vecCtrl",   A_CTRL,   vec[i].expCtrl);
            checkReg("vecBase",   A_BASE,   vec[i].base);
            checkReg("vecStatus", A_STATUS, 32'h0004_0000);
        end

        // Two back-to-back words: the second stalls three cycles and the
        // eight bytes come out contiguously.
        wr(A_BASE, 32'h040);
        wr(A_CTRL, 32'h101);
        applyStimulus(A_DATA, 32'h13121110, st1, acc1);
        pushWord(acc1, 32'h13121110, 4'b0010, 10'h040, 4, -1);
        applyStimulus(A_DATA, 32'h17161514, st2, acc2);
        pushWord(acc2, 32'h17161514, 4'b0010, 10'h044, 4, -1);
        checkOutput("b2bFirstStalls",  32'(st1), 32'd0);
        checkOutput("b2bSecondStalls", 32'(st2), 32'd3);
        waitDrain();
        checkReg("b2bStatus", A_STATUS, 32'h0008_0000);

        // LIMIT=6: six bytes, done with the sixth, then a refused third word.
        wr(A_LIMIT, 32'd6);
        wr(A_BASE, 32'h080);
        wr(A_CTRL, 32'h101);
        applyStimulus(A_DATA, 32'h04030201, st1, acc1);
        pushWord(acc1, 32'h04030201, 4'b0010, 10'h080, 4, -1);
        applyStimulus(A_DATA, 32'h08070605, st2, acc2);
        pushWord(acc2, 32'h08070605, 4'b0010, 10'h084, 2, 1);
        waitDrain();
        applyStimulus(A_DATA, 32'hCAFEF00D, st1, acc1);
        checkOutput("limitThirdStalls", 32'(st1), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkReg("limitStatus", A_STATUS, 32'h0006_0006);
        checkReg("limitReg",    A_LIMIT,  32'd6);
        wr(A_CTRL, 32'h100);
        wr(A_LIMIT, 32'd0);
        checkReg("startClears", A_STATUS, 32'd0);

        // Bank index out of range: the word is refused and err is set.
        wr(A_CTRL, 32'h104);
        applyStimulus(A_DATA, 32'h55AA55AA, st1, acc1);
        repeat (6) @(posedge clk);
        #1;
        checkReg("badBankStatus", A_STATUS, 32'h0000_0004);
        wr(A_CTRL, 32'h100);

        // Reset after lane 1: no further bank writes, registers cleared.
        wr(A_BASE, 32'h030);
        wr(A_CTRL, 32'h101);
        applyStimulus(A_DATA, 32'h87654321, st1, acc1);
        pushWord(acc1, 32'h87654321, 4'b0010, 10'h030, 2, -1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("resetAbortDrained", 32'(sbQ.size()), 32'd0);
        checkReg("resetAbortStatus", A_STATUS, 32'd0);
        checkReg("resetAbortBase",   A_BASE,   32'd0);
        checkReg("resetAbortCtrl",   A_CTRL,   32'd0);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("finalScoreboard", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/acc_loader.md
ACC_LOADER -- requirements
Module: acc_loader

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of destination RAM banks, range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 10: bank address width.
REQ-003 SHALL have parameter DATA_W, fixed 8: byte lane width; four lanes packed per 32-bit word.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port chipselect, input, 1: slave select.
REQ-007 SHALL have port write, input, 1: write strobe.
REQ-008 SHALL have port read, input, 1: read strobe.
REQ-009 SHALL have port address, input, 3: register select; 0 CTRL, 1 DATA, 2 BASE, 3 LIMIT, 4 STATUS.
REQ-010 SHALL have port writedata, input, 32: register write data.
REQ-011 SHALL have port readdata, output, 32: register read data.
REQ-012 SHALL have port waitrequest, output, 1: stall; the access is not taken while high.
REQ-013 SHALL have port wren, output, NUM_BANKS: one-hot (or all-ones in broadcast) bank write enable.
REQ-014 SHALL have port waddr, output, ADDR_W: bank write address.
REQ-015 SHALL have port wdata, output, 8: bank write byte.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when LIMIT bytes are written.

Function
REQ-017 SHALL implement FSM IDLE -> UNPACK (lane counter 0..3) -> IDLE; accepted DATA write in IDLE latches the word and enters UNPACK.
REQ-018 SHALL emit lane 0 (writedata[7:0]) first, one byte per cycle; first wren is 1 cycle after acceptance; lane 3 is 4 cycles after.
REQ-019 SHALL increment ptr by 1 after each emitted byte; waddr = ptr; ptr wraps 2^ADDR_W-1 -> 0.
REQ-020 SHALL assert waitrequest for any chipselect access while in UNPACK with lane < 3; in lane 3 the access is taken, giving back-to-back throughput of 4 cycles per word.
REQ-021 SHALL decode CTRL: [3:0] bank index, [4] broadcast, [8] start; start clears ptr-to-BASE reload, byte count, done_sticky and err.
REQ-022 SHALL write BASE[ADDR_W-1:0] into ptr immediately when written in IDLE.
REQ-023 SHALL count emitted bytes (16-bit); when count reaches LIMIT[15:0] (LIMIT != 0), pulse done, set done_sticky, drop remaining lanes of the current word, return to IDLE.
REQ-024 SHALL ignore DATA writes while done_sticky or bank index >= NUM_BANKS, and set err.
REQ-025 SHALL return readdata 1 cycle after an accepted read; STATUS = {count[15:0], 13'b0, err, done_sticky, busy}; other addresses return their register value; reads have no side effects.
REQ-026 SHALL drive wren to all zeros outside UNPACK.

Reset
REQ-027 SHALL, on reset, clear state to IDLE, ptr, count, CTRL, BASE, LIMIT, err, done_sticky, readdata, wren, waddr, wdata, done, waitrequest to 0.
REQ-028 SHALL abort UNPACK on reset mid-word with no further wren.

Configuration
REQ-029 SHALL, when macro ACC_LOADER_BROADCAST_EN is defined, assert all wren bits per byte when CTRL[4]=1.
REQ-030 SHALL, when ACC_LOADER_BROADCAST_EN is undefined, ignore CTRL[4] and read it back as 0.

Verification
REQ-031 SHALL cover: CTRL=1, BASE=0x10, DATA=0xDDCCBBAA -> wren=4'b0010 at addr 0x10..0x13 with bytes AA,BB,CC,DD on cycles +1..+4.
REQ-032 SHALL cover: two back-to-back DATA writes -> second stalls 3 cycles, 8 contiguous bytes, no gap.
REQ-033 SHALL cover: BASE=0x3FE, one DATA write -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-034 SHALL cover: LIMIT=6, two DATA writes -> 6 bytes written, done pulse with byte 6, third DATA write sets err, STATUS reads 0x00060006.
REQ-035 SHALL cover: reset asserted after lane 1 -> no wren afterwards, STATUS reads 0.
REQ-036 SHALL cover: broadcast built in, CTRL=0x10 -> wren=4'b1111; without macro -> wren=4'b0001.
